// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the two-port RAM arbiter
// Contents: lock FSM state type, port-id constants, legal read-latency bounds.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/ram_arb_rtag.sv
// rtl/ram_arb_rtag.sv - RD_LAT-deep (valid, port-id) read tag pipeline
// Ports:
//   clk, rst_n         clock, asynchronous active-low clear (drops in-flight tags)
//   push_valid_i       a read is on the RAM pins this cycle
//   push_id_i          port that issued that read
//   pop_valid_o        read data for a tagged read is on ram_rd_data this cycle
//   pop_id_o           port the returning data belongs to
module ram_arb_rtag
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid_i,
    input  logic push_id_i,
    output logic pop_valid_o,
    output logic pop_id_o
);

    // Out-of-range latencies are clamped to the nearest legal depth.
    localparam int DEPTH = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] id_q;

    generate
        if (DEPTH == 1) begin : g_depth1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    id_q  <= '0;
                end else begin
                    vld_q <= push_valid_i;
                    id_q  <= push_id_i;
                end
            end
        end else begin : g_depthn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    id_q  <= '0;
                end else begin
                    vld_q <= {vld_q[DEPTH-2:0], push_valid_i};
                    id_q  <= {id_q[DEPTH-2:0], push_id_i};
                end
            end
        end
    endgenerate

    assign pop_valid_o = vld_q[DEPTH-1];
    assign pop_id_o    = id_q[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter for one single-port block RAM
// Build option: RAM_ARB_FIXED_PRIO_EN (A has strict priority in ARB; else round robin)
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   a_*/b_* req,lock,we,addr,wdata  requester payloads (held while req & !gnt)
//   a_gnt, b_gnt                    combinational grants; transfer = req & gnt at edge
//   a_rvalid/a_rdata, b_*           one-cycle read return strobe and data
//   ram_en, ram_we, ram_addr,       registered RAM control pins
//   ram_wr_data, ram_rd_data        RAM write / read data
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_lock,
    input  logic              b_lock,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    arb_state_e        state_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wr_data_q;
    logic              ram_id_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic              last_q;
`endif

    logic xfer;
    logic sel_we;
    logic tag_vld;
    logic tag_id;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        case (state_q)
            ARB: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                a_gnt = a_req;
                b_gnt = b_req & ~a_req;
`else
                // On contention the port that did not win last time goes first.
                a_gnt = a_req & (~b_req | (last_q == PORT_B));
                b_gnt = b_req & ~a_gnt;
`endif
            end
            LOCK_A:  a_gnt = a_req;
            LOCK_B:  b_gnt = b_req;
            default: ;
        endcase
        if (!rst_n) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end
    end

    assign xfer   = a_gnt | b_gnt;
    assign sel_we = b_gnt ? b_we : a_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            ram_id_q      <= PORT_A;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_q        <= PORT_B;
`endif
        end else begin
            ram_en_q <= xfer;
            ram_we_q <= xfer & sel_we;
            if (xfer) begin
                ram_addr_q    <= b_gnt ? b_addr  : a_addr;
                ram_wr_data_q <= b_gnt ? b_wdata : a_wdata;
                ram_id_q      <= b_gnt ? PORT_B  : PORT_A;
`ifndef RAM_ARB_FIXED_PRIO_EN
                last_q        <= b_gnt ? PORT_B  : PORT_A;
`endif
            end
            case (state_q)
                ARB: begin
                    if (a_gnt && a_lock)      state_q <= LOCK_A;
                    else if (b_gnt && b_lock) state_q <= LOCK_B;
                end
                // In a locked state gnt == req, so the lock is released either by
                // an unlocked transfer or by the owner dropping req.
                LOCK_A:  if (!(a_req && a_lock)) state_q <= ARB;
                LOCK_B:  if (!(b_req && b_lock)) state_q <= ARB;
                default: state_q <= ARB;
            endcase
        end
    end

    // Tags enter when the read is actually on the RAM pins, so the pipeline
    // depth equals the RAM read latency.
    ram_arb_rtag #(
        .RD_LAT (RD_LAT)
    ) u_rtag (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (ram_en_q & ~ram_we_q),
        .push_id_i    (ram_id_q),
        .pop_valid_o  (tag_vld),
        .pop_id_o     (tag_id)
    );

    assign a_rvalid    = tag_vld & (tag_id == PORT_A);
    assign b_rvalid    = tag_vld & (tag_id == PORT_B);
    assign a_rdata     = ram_rd_data;
    assign b_rdata     = ram_rd_data;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;

endmodule
